load_buffer: RTL and testbench

- Holds up to LOAD_BUFFER_DEPTH issued loads and waits until each load's base operand is available.
- Computes each load's effective address and publishes every entry's ROB index and address to the reorder buffer for store-conflict checking.
- Issues one data-memory read at a time for the lowest-index entry the ROB clears, aligns and extends the read data, and presents the result to the CDB arbiter.
- Sits between issue and the ROB/CDB, in parallel with the ALU reservation stations.

---
 rtl/load_buffer_pkg.sv | 23 ++
 rtl/load_align.sv | 42 ++++
 rtl/load_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_load_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_buffer_pkg.sv
// Shared load-buffer types: load funct3 encodings, the LOAD opcode and the
// memory-read sequencer state encoding.
package load_buffer_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        LB_IDLE     = 2'd0,
        LB_WAIT_MEM = 2'd1,
        LB_HOLD     = 2'd2
    } lb_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it
// according to the load funct3; misaligned halves stay within the word.
module load_align
    import load_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction and extension.
    always_comb begin
        byte_s = word[7:0];
        half_s = word[15:0];
        value  = word;
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_LB:   value = {{24{byte_s[7]}}, byte_s};
            F3_LH:   value = {{16{half_s[15]}}, half_s};
            F3_LW:   value = word;
            F3_LBU:  value = {24'd0, byte_s};
            F3_LHU:  value = {16'd0, half_s};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// Load buffer: holds issued loads until their base resolves, exposes their
// addresses to the ROB, and runs one data-memory read at a time.
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int ROB_SIZE          = 8,
    parameter int LOAD_BUFFER_DEPTH = 3,
    parameter int MEM_LATENCY       = 2,
    localparam int ROB_IX           = $clog2(ROB_SIZE) - 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  valid_in,
    input  logic [ROB_IX:0]                       rob_ix_in,
    input  logic [2:0]                            funct3_in,
    input  logic [31:0]                           base_value_in,
    input  logic                                  base_ready_in,
    input  logic [ROB_IX:0]                       base_tag_in,
    input  logic [31:0]                           offset_in,
    output logic                                  ready_out,
    input  logic                                  cdb_valid_in,
    input  logic [ROB_IX:0]                       cdb_rob_ix_in,
    input  logic [31:0]                           cdb_value_in,
    input  logic                                  flush_in,
    output logic [(ROB_IX+1)*LOAD_BUFFER_DEPTH-1:0] lb_rob_arr_ix_out,
    output logic [32*LOAD_BUFFER_DEPTH-1:0]       lb_rob_arr_dest_out,
    input  logic [LOAD_BUFFER_DEPTH-1:0]          can_load_in,
    output logic [31:0]                           mem_addr_out,
    output logic                                  mem_re_out,
    input  logic [31:0]                           mem_rdata_in,
    output logic                                  result_valid_out,
    output logic [ROB_IX:0]                       result_rob_ix_out,
    output logic [31:0]                           result_value_out,
    input  logic                                  result_grant_in
);

    localparam int DEPTH = LOAD_BUFFER_DEPTH;
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    logic [DEPTH-1:0] valid_r, addr_ready_r, issued_r;
    logic [ROB_IX:0]  rob_ix_r   [DEPTH];
    logic [ROB_IX:0]  base_tag_r [DEPTH];
    logic [2:0]       funct3_r   [DEPTH];
    logic [31:0]      base_r     [DEPTH];
    logic [31:0]      offset_r   [DEPTH];

    lb_state_t        state_r;
    logic [SEL_W-1:0] cur_ix_r;
    logic [CNT_W-1:0] lat_cnt_r;
    logic             mem_re_r, result_valid_r;
    logic [31:0]      mem_addr_r, result_value_r;
    logic [ROB_IX:0]  result_rob_ix_r;

    logic [31:0]      eff_addr_s [DEPTH];
    logic [DEPTH-1:0] cand_s, addr_on_s;
    logic             alloc_found_s, sel_found_s, alloc_hit_s;
    logic [SEL_W-1:0] alloc_ix_s, sel_ix_s;
    logic [2:0]       cur_funct3_s;
    logic [1:0]       cur_addr_lo_s;
    logic [31:0]      aligned_s;

    assign cand_s        = valid_r & addr_ready_r & ~issued_r & can_load_in;
    assign addr_on_s     = valid_r & addr_ready_r;
    assign alloc_hit_s   = !base_ready_in && cdb_valid_in && (cdb_rob_ix_in == base_tag_in);
    assign ready_out     = ~(&valid_r);
    assign cur_funct3_s  = funct3_r[cur_ix_r];
    assign cur_addr_lo_s = eff_addr_s[cur_ix_r][1:0];

    assign mem_re_out        = mem_re_r;
    assign mem_addr_out      = mem_addr_r;
    assign result_valid_out  = result_valid_r;
    assign result_rob_ix_out = result_rob_ix_r;
    assign result_value_out  = result_value_r;

    // Effective addresses plus lowest-index free slot and lowest-index issuable entry.
    always_comb begin
        alloc_found_s = 1'b0;
        alloc_ix_s    = '0;
        sel_found_s   = 1'b0;
        sel_ix_s      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            eff_addr_s[i] = base_r[i] + offset_r[i];
            alloc_found_s = alloc_found_s | ~valid_r[i];
            alloc_ix_s    = valid_r[i] ? alloc_ix_s : SEL_W'(i);
            sel_found_s   = sel_found_s | cand_s[i];
            sel_ix_s      = cand_s[i] ? SEL_W'(i) : sel_ix_s;
        end
    end

    // Per-entry ROB index and address published for store-conflict checks.
    always_comb begin
        lb_rob_arr_ix_out   = '0;
        lb_rob_arr_dest_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lb_rob_arr_ix_out[i*(ROB_IX+1) +: (ROB_IX+1)] = addr_on_s[i] ? rob_ix_r[i] : '0;
            lb_rob_arr_dest_out[i*32 +: 32]               = addr_on_s[i] ? eff_addr_s[i] : 32'd0;
        end
    end

    load_align u_align (
        .funct3  (cur_funct3_s),
        .addr_lo (cur_addr_lo_s),
        .word    (mem_rdata_in),
        .value   (aligned_s)
    );

    // Entry storage: allocation, CDB snoop, issue marking and release on grant.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r      <= '0;
            addr_ready_r <= '0;
            issued_r     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_ix_r[i]   <= '0;
                base_tag_r[i] <= '0;
                funct3_r[i]   <= 3'd0;
                base_r[i]     <= 32'd0;
                offset_r[i]   <= 32'd0;
            end
        end else if (flush_in) begin
            valid_r      <= '0;
            addr_ready_r <= '0;
            issued_r     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && !addr_ready_r[i] && cdb_valid_in && (base_tag_r[i] == cdb_rob_ix_in)) begin
                    base_r[i]       <= cdb_value_in;
                    addr_ready_r[i] <= 1'b1;
                end
            end
            if (state_r == LB_IDLE && sel_found_s) begin
                issued_r[sel_ix_s] <= 1'b1;
            end
            if (state_r == LB_HOLD && result_grant_in) begin
                valid_r[cur_ix_r]      <= 1'b0;
                addr_ready_r[cur_ix_r] <= 1'b0;
                issued_r[cur_ix_r]     <= 1'b0;
            end
            // ready_out is registered state, so a slot freed this edge is not reused until next cycle.
            if (valid_in && ready_out && alloc_found_s) begin
                valid_r[alloc_ix_s]      <= 1'b1;
                addr_ready_r[alloc_ix_s] <= base_ready_in || alloc_hit_s;
                issued_r[alloc_ix_s]     <= 1'b0;
                rob_ix_r[alloc_ix_s]     <= rob_ix_in;
                funct3_r[alloc_ix_s]     <= funct3_in;
                base_tag_r[alloc_ix_s]   <= base_tag_in;
                offset_r[alloc_ix_s]     <= offset_in;
                base_r[alloc_ix_s]       <= alloc_hit_s ? cdb_value_in : base_value_in;
            end
        end
    end

    // Memory-read sequencer with registered strobe, address and result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r         <= LB_IDLE;
            cur_ix_r        <= '0;
            lat_cnt_r       <= '0;
            mem_re_r        <= 1'b0;
            mem_addr_r      <= 32'd0;
            result_valid_r  <= 1'b0;
            result_rob_ix_r <= '0;
            result_value_r  <= 32'd0;
        end else if (flush_in) begin
            state_r        <= LB_IDLE;
            mem_re_r       <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                LB_IDLE: begin
                    if (sel_found_s) begin
                        mem_re_r   <= 1'b1;
                        mem_addr_r <= word_align(eff_addr_s[sel_ix_s]);
                        cur_ix_r   <= sel_ix_s;
                        lat_cnt_r  <= '0;
                        state_r    <= LB_WAIT_MEM;
                    end else begin
                        mem_re_r <= 1'b0;
                    end
                end
                LB_WAIT_MEM: begin
                    mem_re_r <= 1'b0;
                    if (lat_cnt_r == CNT_W'(MEM_LATENCY)) begin
                        result_value_r  <= aligned_s;
                        result_rob_ix_r <= rob_ix_r[cur_ix_r];
                        result_valid_r  <= 1'b1;
                        state_r         <= LB_HOLD;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 1'b1;
                    end
                end
                LB_HOLD: begin
                    if (result_grant_in) begin
                        result_valid_r <= 1'b0;
                        state_r        <= LB_IDLE;
                    end
                end
                default: begin
                    state_r        <= LB_IDLE;
                    mem_re_r       <= 1'b0;
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Directed and randomized bench for load_buffer against a slot-level reference model.
module tb_load_buffer;
    import load_buffer_pkg::*;

    localparam int DEPTH = 3;
    localparam int LAT   = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, valid_in, base_ready_in, cdb_valid_in, flush_in, result_grant_in;
    logic [2:0]  rob_ix_in, funct3_in, base_tag_in, cdb_rob_ix_in, can_load_in, result_rob_ix_out;
    logic [31:0] base_value_in, offset_in, cdb_value_in, mem_addr_out, mem_rdata_in, result_value_out;
    logic        ready_out, mem_re_out, result_valid_out;
    logic [8:0]  lb_rob_arr_ix_out;
    logic [95:0] lb_rob_arr_dest_out;

    int n_cmp = 0;
    int n_bad = 0;

    load_buffer #(.ROB_SIZE(8), .LOAD_BUFFER_DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .rob_ix_in(rob_ix_in),
        .funct3_in(funct3_in), .base_value_in(base_value_in), .base_ready_in(base_ready_in),
        .base_tag_in(base_tag_in), .offset_in(offset_in), .ready_out(ready_out),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_value_in(cdb_value_in),
        .flush_in(flush_in), .lb_rob_arr_ix_out(lb_rob_arr_ix_out),
        .lb_rob_arr_dest_out(lb_rob_arr_dest_out), .can_load_in(can_load_in),
        .mem_addr_out(mem_addr_out), .mem_re_out(mem_re_out), .mem_rdata_in(mem_rdata_in),
        .result_valid_out(result_valid_out), .result_rob_ix_out(result_rob_ix_out),
        .result_value_out(result_value_out), .result_grant_in(result_grant_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h108) return 32'hDEADBEEF;
        if (w == 32'h200) return 32'h80C35A17;
        return (w * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Memory responder: data is valid in the cycle LAT cycles after the strobe, garbage otherwise.
    bit          pv [LAT+1];
    logic [31:0] pa [LAT+1];
    always @(negedge clk_in) begin
        for (int j = LAT; j > 0; j--) begin
            pv[j] = pv[j-1];
            pa[j] = pa[j-1];
        end
        pv[0] = mem_re_out;
        pa[0] = mem_addr_out;
        if (pv[LAT]) mem_rdata_in = mem_word(pa[LAT]);
        else         mem_rdata_in = $urandom;
    end

    // Reference model: slot contents plus a read tracker.
    bit          m_v [DEPTH], m_r [DEPTH], m_i [DEPTH];
    logic [31:0] m_base [DEPTH], m_off [DEPTH];
    logic [2:0]  m_rob [DEPTH], m_tag [DEPTH], m_f3 [DEPTH];
    int          m_state, m_cur, m_cnt;
    bit          exp_re, exp_rv;
    logic [31:0] exp_addr, exp_val;
    logic [2:0]  exp_tag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0; m_r[i] = 1'b0; m_i[i] = 1'b0;
        end
        m_state = 0; exp_re = 1'b0; exp_rv = 1'b0;
    endtask

    task automatic check_outputs();
        bit any_free;
        any_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_free |= !m_v[i];
        check("ready", 32'(ready_out), 32'(any_free));
        check("mem_re", 32'(mem_re_out), 32'(exp_re));
        if (exp_re) check("mem_addr", mem_addr_out, exp_addr);
        check("res_valid", 32'(result_valid_out), 32'(exp_rv));
        if (exp_rv) begin
            check("res_tag", 32'(result_rob_ix_out), 32'(exp_tag));
            check("res_value", result_value_out, exp_val);
        end
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("arr_ix%0d", i), 32'(lb_rob_arr_ix_out[i*3 +: 3]),
                  (m_v[i] && m_r[i]) ? 32'(m_rob[i]) : 32'd0);
            check($sformatf("arr_dest%0d", i), lb_rob_arr_dest_out[i*32 +: 32],
                  (m_v[i] && m_r[i]) ? (m_base[i] + m_off[i]) : 32'd0);
        end
    endtask

    // One clock: advance the model from the driven inputs, clock the DUT, compare.
    task automatic step();
        int fi, cand;
        logic [31:0] a;
        fi = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fi = i;
        if (flush_in) begin
            reset_model();
        end else begin
            exp_re = 1'b0;
            if (m_state == 0) begin
                cand = -1;
                for (int i = DEPTH - 1; i >= 0; i--)
                    if (m_v[i] && m_r[i] && !m_i[i] && can_load_in[i]) cand = i;
                if (cand >= 0) begin
                    exp_re = 1'b1;
                    exp_addr = (m_base[cand] + m_off[cand]) & 32'hFFFFFFFC;
                    m_i[cand] = 1'b1; m_cur = cand; m_cnt = LAT + 1; m_state = 1;
                end
            end else if (m_state == 1) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    a = m_base[m_cur] + m_off[m_cur];
                    exp_val = exp_load(m_f3[m_cur], a, mem_word(a));
                    exp_tag = m_rob[m_cur];
                    exp_rv = 1'b1; m_state = 2;
                end
            end else if (result_grant_in) begin
                m_v[m_cur] = 1'b0; m_r[m_cur] = 1'b0; m_i[m_cur] = 1'b0;
                exp_rv = 1'b0; m_state = 0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m_v[i] && !m_r[i] && cdb_valid_in && m_tag[i] == cdb_rob_ix_in) begin
                    m_r[i] = 1'b1; m_base[i] = cdb_value_in;
                end
            end
            if (valid_in && fi >= 0) begin
                m_v[fi] = 1'b1; m_i[fi] = 1'b0;
                m_rob[fi] = rob_ix_in; m_f3[fi] = funct3_in; m_tag[fi] = base_tag_in; m_off[fi] = offset_in;
                m_r[fi] = base_ready_in || (cdb_valid_in && cdb_rob_ix_in == base_tag_in);
                m_base[fi] = base_ready_in ? base_value_in : cdb_value_in;
            end
        end
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    task automatic issue(input logic [2:0] rob, input logic [2:0] f3, input logic [31:0] base,
                         input logic rdy, input logic [2:0] tag, input logic [31:0] off);
        valid_in = 1'b1; rob_ix_in = rob; funct3_in = f3; base_value_in = base;
        base_ready_in = rdy; base_tag_in = tag; offset_in = off;
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_result();
        for (int k = 0; k < 10 && !result_valid_out; k++) step();
        check("rv_wait", 32'(result_valid_out), 32'd1);
    endtask

    task automatic grant_once();
        result_grant_in = 1'b1;
        step();
        result_grant_in = 1'b0;
    endtask

    logic [2:0] f3_tab [5];

    initial begin
        f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW; f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;
        rst_in = 1'b1; valid_in = 1'b0; rob_ix_in = 3'd0; funct3_in = 3'd0; base_value_in = 32'd0;
        base_ready_in = 1'b0; base_tag_in = 3'd0; offset_in = 32'd0; cdb_valid_in = 1'b0;
        cdb_rob_ix_in = 3'd0; cdb_value_in = 32'd0; flush_in = 1'b0; can_load_in = 3'b111;
        result_grant_in = 1'b0;
        reset_model();
        #12;
        check("rst_addr", mem_addr_out, 32'd0);
        check("rst_tag", 32'(result_rob_ix_out), 32'd0);
        check("rst_value", result_value_out, 32'd0);
        check_outputs();
        rst_in = 1'b0;

        // Ready operands, LW.
        issue(3'd3, F3_LW, 32'h100, 1'b1, 3'd0, 32'd8);
        wait_result();
        check("t1_tag", 32'(result_rob_ix_out), 32'd3);
        check("t1_value", result_value_out, 32'hDEADBEEF);
        step();
        grant_once();
        step();

        // Pending base resolved by CDB, LB then LBU.
        for (int rep = 0; rep < 2; rep++) begin
            issue(3'd2, (rep == 0) ? F3_LB : F3_LBU, 32'd0, 1'b0, 3'd5, 32'hFFFFFFFF);
            step();
            cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd5; cdb_value_in = 32'h204;
            step();
            cdb_valid_in = 1'b0;
            wait_result();
            check("t2_value", result_value_out, (rep == 0) ? 32'hFFFFFF80 : 32'h00000080);
            grant_once();
        end

        // Allocation-cycle CDB hit.
        can_load_in = 3'b000;
        cdb_valid_in = 1'b1; cdb_rob_ix_in = 3'd5; cdb_value_in = 32'h300;
        issue(3'd4, F3_LW, 32'd0, 1'b0, 3'd5, 32'd4);
        cdb_valid_in = 1'b0;
        check("t3_dest", lb_rob_arr_dest_out[31:0], 32'h304);
        can_load_in = 3'b111;
        wait_result();
        grant_once();

        // Full and blocked.
        can_load_in = 3'b000;
        issue(3'd1, F3_LW, 32'h400, 1'b1, 3'd0, 32'd0);
        issue(3'd2, F3_LW, 32'h410, 1'b1, 3'd0, 32'd0);
        issue(3'd3, F3_LW, 32'h420, 1'b1, 3'd0, 32'd0);
        check("t4_full", 32'(ready_out), 32'd0);
        issue(3'd4, F3_LW, 32'h430, 1'b1, 3'd0, 32'd0);
        step();
        can_load_in = 3'b010;
        step();
        check("t4_re", 32'(mem_re_out), 32'd1);
        check("t4_addr", mem_addr_out, 32'h410);
        wait_result();
        check("t4_tag", 32'(result_rob_ix_out), 32'd2);
        can_load_in = 3'b111;
        result_grant_in = 1'b1;
        for (int k = 0; k < 16; k++) step();
        result_grant_in = 1'b0;

        // Flush during WAIT_MEM.
        issue(3'd6, F3_LW, 32'h500, 1'b1, 3'd0, 32'd0);
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("t5_ready", 32'(ready_out), 32'd1);
        for (int k = 0; k < 6; k++) step();

        // Asynchronous reset during HOLD.
        issue(3'd7, F3_LHU, 32'h602, 1'b1, 3'd0, 32'd0);
        wait_result();
        #3 rst_in = 1'b1;
        #1;
        check("t6_rv", 32'(result_valid_out), 32'd0);
        check("t6_re", 32'(mem_re_out), 32'd0);
        check("t6_ready", 32'(ready_out), 32'd1);
        reset_model();
        #2 rst_in = 1'b0;
        step();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            valid_in        = 1'($urandom_range(0, 1));
            rob_ix_in       = 3'($urandom);
            funct3_in       = f3_tab[$urandom_range(0, 4)];
            base_value_in   = $urandom;
            base_ready_in   = ($urandom_range(0, 3) != 0);
            base_tag_in     = 3'($urandom);
            offset_in       = 32'($urandom_range(0, 64)) - 32'd32;
            cdb_valid_in    = ($urandom_range(0, 2) == 0);
            cdb_rob_ix_in   = 3'($urandom);
            cdb_value_in    = $urandom;
            can_load_in     = 3'($urandom_range(0, 7));
            result_grant_in = 1'($urandom_range(0, 1));
            flush_in        = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
